// File: rtl/operand_seq_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : operand_seq_pkg                                               |
// | Purpose  : Shared constants, state encoding and address helper for the   |
// |            operand matrix sequencer and its index counter.               |
// | Contents : DATA_WIDTH, MAX_DIM, ADDR_WIDTH, IDX_WIDTH, DIM_WIDTH,        |
// |            state_e, compose_addr()                                       |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
package operand_seq_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int MAX_DIM    = 4;
  localparam int ADDR_WIDTH = $clog2(MAX_DIM * MAX_DIM);
  localparam int IDX_WIDTH  = $clog2(MAX_DIM);
  localparam int DIM_WIDTH  = 3;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD     = 3'd1,
    RD_ISSUE = 3'd2,
    RD_DATA  = 3'd3,
    DONE     = 3'd4
  } state_e;

  // Locations are laid out on a fixed MAX_DIM pitch regardless of N, so a
  // smaller matrix occupies the top-left corner of the register file.
  function automatic logic [ADDR_WIDTH-1:0] compose_addr(
    input logic [IDX_WIDTH-1:0] row,
    input logic [IDX_WIDTH-1:0] col
  );
    return ADDR_WIDTH'(int'(row) * MAX_DIM + int'(col));
  endfunction

endpackage
`default_nettype wire

// File: rtl/operand_seq_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : operand_seq_if                                                |
// | Purpose  : Command, load-stream, readout-stream and register-file bus    |
// |            of the operand sequencer.                                     |
// | Modports : slave  - the sequencer (consumes commands/stream, drives RF)  |
// |            master - host side / register file / consumer                 |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
interface operand_seq_if;
  import operand_seq_pkg::*;

  // command
  logic                  start_i;
  logic [DIM_WIDTH-1:0]  dim_i;
  logic                  transpose_i;
  // load stream
  logic [DATA_WIDTH-1:0] in_data_i;
  logic                  in_valid_i;
  logic                  in_ready_o;
  // readout stream
  logic [DATA_WIDTH-1:0] out_data_o;
  logic                  out_valid_o;
  logic                  out_ready_i;
  logic                  out_last_o;
  // status
  logic                  busy_o;
  logic                  done_o;
  logic                  err_o;
  // register-file port
  logic [ADDR_WIDTH-1:0] mat_addr_o;
  logic [DATA_WIDTH-1:0] mat_wdata_o;
  logic                  mat_we_o;
  logic [DATA_WIDTH-1:0] mat_rdata_i;

  modport slave (
    input  start_i, dim_i, transpose_i,
    input  in_data_i, in_valid_i,
    output in_ready_o,
    output out_data_o, out_valid_o, out_last_o,
    input  out_ready_i,
    output busy_o, done_o, err_o,
    output mat_addr_o, mat_wdata_o, mat_we_o,
    input  mat_rdata_i
  );

  modport master (
    output start_i, dim_i, transpose_i,
    output in_data_i, in_valid_i,
    input  in_ready_o,
    input  out_data_o, out_valid_o, out_last_o,
    output out_ready_i,
    input  busy_o, done_o, err_o,
    input  mat_addr_o, mat_wdata_o, mat_we_o,
    output mat_rdata_i
  );

endinterface
`default_nettype wire

// File: rtl/operand_idx_counter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : operand_idx_counter                                           |
// | Purpose  : Two-level (outer/inner) index counter wrapping at N, shared   |
// |            by the load and readout phases.                               |
// | Ports    : clk_i, rst_ni  - clock, async active-low reset                |
// |            clr_i          - zero both indices (wins over adv_i)          |
// |            adv_i          - step inner index, carry into outer at N-1    |
// |            n_i            - matrix dimension N                           |
// |            swap_i         - 1: row = inner, col = outer (column-major)   |
// |            row_o, col_o   - current matrix coordinates                   |
// |            last_o         - both indices at N-1                          |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module operand_idx_counter
  import operand_seq_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clr_i,
  input  logic                 adv_i,
  input  logic [DIM_WIDTH-1:0] n_i,
  input  logic                 swap_i,
  output logic [IDX_WIDTH-1:0] row_o,
  output logic [IDX_WIDTH-1:0] col_o,
  output logic                 last_o
);

  logic [IDX_WIDTH-1:0] outer_q, outer_d;
  logic [IDX_WIDTH-1:0] inner_q, inner_d;
  logic                 w_inner_wrap;
  logic                 w_outer_wrap;

  assign w_inner_wrap = (DIM_WIDTH'(inner_q) == n_i - DIM_WIDTH'(1));
  assign w_outer_wrap = (DIM_WIDTH'(outer_q) == n_i - DIM_WIDTH'(1));
  assign last_o       = w_inner_wrap & w_outer_wrap;

  always_comb begin
    outer_d = outer_q;
    inner_d = inner_q;
    if (clr_i) begin
      outer_d = '0;
      inner_d = '0;
    end else if (adv_i) begin
      if (w_inner_wrap) begin
        inner_d = '0;
        outer_d = w_outer_wrap ? '0 : outer_q + IDX_WIDTH'(1);
      end else begin
        inner_d = inner_q + IDX_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      outer_q <= '0;
      inner_q <= '0;
    end else begin
      outer_q <= outer_d;
      inner_q <= inner_d;
    end
  end

  // Column-major walk keeps the same counting order but maps the fast
  // (inner) index onto the row.
  assign row_o = swap_i ? inner_q : outer_q;
  assign col_o = swap_i ? outer_q : inner_q;

endmodule
`default_nettype wire

// File: rtl/operand_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : operand_seq                                                   |
// | Purpose  : Loads an NxN operand matrix into an external register file in |
// |            row-major order, then replays it row- or column-major.        |
// | Ports    : clk_i   - clock, rising edge                                  |
// |            rst_ni  - asynchronous active-low reset                       |
// |            bus     - operand_seq_if.slave: command, load stream,         |
// |                      readout stream, status, register-file port          |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module operand_seq
  import operand_seq_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_ni,
  operand_seq_if.slave bus
);

  state_e               state_q;
  logic [DIM_WIDTH-1:0] n_q;
  logic                 transpose_q;
  logic                 in_ready_q;
  logic                 out_valid_q;
  logic                 out_last_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 err_q;

  logic                 w_dim_ok;
  logic                 w_load_hs;
  logic                 w_out_hs;
  logic                 w_cnt_clr;
  logic                 w_cnt_adv;
  logic                 w_cnt_swap;
  logic                 w_cnt_last;
  logic [IDX_WIDTH-1:0] w_row;
  logic [IDX_WIDTH-1:0] w_col;

  assign w_dim_ok  = (bus.dim_i != '0) && (bus.dim_i <= DIM_WIDTH'(MAX_DIM));
  assign w_load_hs = (state_q == LOAD) && bus.in_valid_i && in_ready_q;
  assign w_out_hs  = (state_q == RD_DATA) && out_valid_q && bus.out_ready_i;

  // Counters restart on an accepted command and after the final element of
  // each phase, so readout always begins at (0,0).
  assign w_cnt_clr  = ((state_q == IDLE) && bus.start_i && w_dim_ok) ||
                      (w_load_hs && w_cnt_last) ||
                      (w_out_hs && w_cnt_last);
  assign w_cnt_adv  = w_load_hs || w_out_hs;
  assign w_cnt_swap = transpose_q && ((state_q == RD_ISSUE) || (state_q == RD_DATA));

  operand_idx_counter u_idx (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (w_cnt_clr),
    .adv_i  (w_cnt_adv),
    .n_i    (n_q),
    .swap_i (w_cnt_swap),
    .row_o  (w_row),
    .col_o  (w_col),
    .last_o (w_cnt_last)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      n_q         <= '0;
      transpose_q <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start_i) begin
            if (w_dim_ok) begin
              state_q     <= LOAD;
              n_q         <= bus.dim_i;
              transpose_q <= bus.transpose_i;
              in_ready_q  <= 1'b1;
              busy_q      <= 1'b1;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (w_load_hs && w_cnt_last) begin
            state_q    <= RD_ISSUE;
            in_ready_q <= 1'b0;
          end
        end
        RD_ISSUE: begin
          // Address is on the bus this cycle; data returns next cycle.
          state_q     <= RD_DATA;
          out_valid_q <= 1'b1;
          out_last_q  <= w_cnt_last;
        end
        RD_DATA: begin
          if (w_out_hs) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            if (w_cnt_last) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= RD_ISSUE;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
          out_last_q  <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready_o  = in_ready_q;
  assign bus.out_valid_o = out_valid_q;
  assign bus.out_last_o  = out_last_q;
  assign bus.busy_o      = busy_q;
  assign bus.done_o      = done_q;
  assign bus.err_o       = err_q;

  // Counter coordinates stay fixed through RD_DATA, holding the read address
  // and therefore the returned data stable under backpressure.
  assign bus.mat_addr_o  = compose_addr(w_row, w_col);
  assign bus.mat_we_o    = bus.in_valid_i & in_ready_q;
  assign bus.mat_wdata_o = bus.in_data_i;
  assign bus.out_data_o  = bus.mat_rdata_i;

endmodule
`default_nettype wire

// File: tb/tb_operand_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_operand_seq                                                |
// | Purpose  : Self-checking bench for operand_seq with a register-file      |
// |            model, directed vector table and randomized commands.         |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_operand_seq;
  import operand_seq_pkg::*;

  logic clk_i = 1'b0;
  logic rst_ni;
  always #5 clk_i = ~clk_i;

  operand_seq_if bus ();

  operand_seq dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  // Register file with one-cycle read latency.
  logic [31:0] mem [16];
  always @(posedge clk_i) begin
    if (bus.mat_we_o) mem[bus.mat_addr_o] <= bus.mat_wdata_o;
    bus.mat_rdata_i <= mem[bus.mat_addr_o];
  end

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor (samples mid-low-phase) ----------------
  int          cyc = 0;
  int          wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  logic [31:0] out_data_q[$];
  bit          out_last_q[$];
  int          done_cnt, err_cnt;
  int          last_wr_cyc, first_ov_cyc, last_out_cyc, done_cyc;
  bit          hold_prev;
  logic [31:0] prev_data;

  task automatic mon_clear();
    wr_addr_q.delete(); wr_data_q.delete();
    out_data_q.delete(); out_last_q.delete();
    done_cnt = 0; err_cnt = 0;
    last_wr_cyc = -100; first_ov_cyc = -1; last_out_cyc = -100; done_cyc = -100;
    hold_prev = 1'b0; prev_data = '0;
  endtask

  always begin
    @(negedge clk_i);
    #2;
    cyc++;
    if (bus.mat_we_o) begin
      check("we_only_in_load", 32'(bus.busy_o & bus.in_ready_o), 32'd1);
      wr_addr_q.push_back(int'(bus.mat_addr_o));
      wr_data_q.push_back(bus.mat_wdata_o);
      last_wr_cyc = cyc;
    end
    if (hold_prev) begin
      check("hold_valid", 32'(bus.out_valid_o), 32'd1);
      check("hold_data", bus.out_data_o, prev_data);
    end
    if (bus.out_valid_o && first_ov_cyc < 0) first_ov_cyc = cyc;
    if (bus.out_valid_o && bus.out_ready_i) begin
      out_data_q.push_back(bus.out_data_o);
      out_last_q.push_back(bus.out_last_o);
      last_out_cyc = cyc;
    end
    if (bus.done_o) begin done_cnt++; done_cyc = cyc; end
    if (bus.err_o) err_cnt++;
    hold_prev = bus.out_valid_o && !bus.out_ready_i;
    prev_data = bus.out_data_o;
  end

  // ---------------- stimulus ----------------
  logic [31:0] ld_data [16];

  // Runs one legal command and compares against a reference built from the
  // matrix itself: writes in row-major order on a MAX_DIM pitch, reads in
  // row-major or column-major element order.
  // rmode: 0 always ready, 1 random ready, 2 stall first element 5 cycles.
  task automatic run_cmd(input int n, input bit tr, input int vpct, input int rmode);
    int          exp_wa[$];
    logic [31:0] exp_wd[$];
    logic [31:0] exp_od[$];
    int          idx, budget, stall_left, load_cycles;
    for (int k = 0; k < n * n; k++) begin
      exp_wa.push_back((k / n) * MAX_DIM + (k % n));
      exp_wd.push_back(ld_data[k]);
    end
    for (int o = 0; o < n; o++)
      for (int i = 0; i < n; i++)
        exp_od.push_back(tr ? ld_data[i * n + o] : ld_data[o * n + i]);

    mon_clear();
    @(negedge clk_i);
    bus.start_i = 1'b1; bus.dim_i = 3'(n); bus.transpose_i = tr;
    @(negedge clk_i);
    bus.dim_i = 3'd0; bus.transpose_i = ~tr;
    check("busy_after_start", 32'(bus.busy_o), 32'd1);
    check("ready_after_start", 32'(bus.in_ready_o), 32'd1);

    idx = 0; budget = 0; load_cycles = 0;
    while (idx < n * n && budget < 400) begin
      bus.start_i    = 1'($urandom_range(1));   // must be ignored while busy
      bus.in_valid_i = (int'($urandom_range(99)) < vpct);
      bus.in_data_i  = bus.in_valid_i ? ld_data[idx] : $urandom;
      if (bus.in_valid_i && bus.in_ready_o) idx++;
      budget++;
      load_cycles++;
      @(negedge clk_i);
    end
    bus.in_valid_i = 1'b0;
    bus.start_i    = 1'b0;
    if (idx < n * n) check("load_timeout", 32'(idx), 32'(n * n));
    if (vpct == 100) check("load_throughput", 32'(load_cycles), 32'(n * n));

    budget = 0; stall_left = 5;
    while (done_cnt == 0 && budget < 300) begin
      case (rmode)
        0: bus.out_ready_i = 1'b1;
        1: bus.out_ready_i = 1'($urandom_range(1));
        default: begin
          if (bus.out_valid_o && stall_left > 0) begin
            bus.out_ready_i = 1'b0;
            stall_left--;
          end else begin
            bus.out_ready_i = 1'b1;
          end
        end
      endcase
      budget++;
      @(negedge clk_i);
    end
    if (done_cnt == 0) check("done_timeout", 32'(done_cnt), 32'd1);
    bus.out_ready_i = 1'b0;
    repeat (2) @(negedge clk_i);

    check("wr_count", 32'(wr_addr_q.size()), 32'(exp_wa.size()));
    for (int k = 0; k < wr_addr_q.size() && k < exp_wa.size(); k++) begin
      check("wr_addr", 32'(wr_addr_q[k]), 32'(exp_wa[k]));
      check("wr_data", wr_data_q[k], exp_wd[k]);
    end
    check("out_count", 32'(out_data_q.size()), 32'(exp_od.size()));
    for (int k = 0; k < out_data_q.size() && k < exp_od.size(); k++) begin
      check("out_data", out_data_q[k], exp_od[k]);
      check("out_last", 32'(out_last_q[k]), 32'(k == n * n - 1));
    end
    check("done_count", 32'(done_cnt), 32'd1);
    check("err_while_busy", 32'(err_cnt), 32'd0);
    check("first_out_latency", 32'(first_ov_cyc - last_wr_cyc), 32'd2);
    check("done_latency", 32'(done_cyc - last_out_cyc), 32'd1);
    if (rmode == 0) check("read_throughput", 32'(last_out_cyc - first_ov_cyc), 32'(2 * (n * n - 1)));
    check("busy_idle", 32'(bus.busy_o), 32'd0);
  endtask

  task automatic run_err(input int d);
    mon_clear();
    @(negedge clk_i);
    bus.start_i = 1'b1; bus.dim_i = 3'(d); bus.in_valid_i = 1'b1;
    @(negedge clk_i);
    bus.start_i = 1'b0;
    check("err_pulse", 32'(bus.err_o), 32'd1);
    check("err_busy", 32'(bus.busy_o), 32'd0);
    check("err_we", 32'(bus.mat_we_o), 32'd0);
    @(negedge clk_i);
    bus.in_valid_i = 1'b0;
    check("err_one_cycle", 32'(bus.err_o), 32'd0);
    check("err_stay_idle", 32'(bus.busy_o | bus.in_ready_o), 32'd0);
    @(negedge clk_i);
  endtask

  typedef struct {
    int          dim;
    bit          tr;
    logic [31:0] base;
    int          rmode;
    int          exp_cnt;
    logic [31:0] exp_last;
    int          exp_err;
  } vec_t;

  vec_t vecs [8];

  initial begin
    vecs[0] = '{dim: 4, tr: 1'b0, base: 32'h0,  rmode: 0, exp_cnt: 16, exp_last: 32'd15,  exp_err: 0};
    vecs[1] = '{dim: 4, tr: 1'b1, base: 32'h0,  rmode: 0, exp_cnt: 16, exp_last: 32'd15,  exp_err: 0};
    vecs[2] = '{dim: 3, tr: 1'b0, base: 32'hA0, rmode: 0, exp_cnt: 9,  exp_last: 32'hA8,  exp_err: 0};
    vecs[3] = '{dim: 1, tr: 1'b0, base: 32'h55, rmode: 0, exp_cnt: 1,  exp_last: 32'h55,  exp_err: 0};
    vecs[4] = '{dim: 0, tr: 1'b0, base: 32'h0,  rmode: 0, exp_cnt: 0,  exp_last: 32'h0,   exp_err: 1};
    vecs[5] = '{dim: 5, tr: 1'b0, base: 32'h0,  rmode: 0, exp_cnt: 0,  exp_last: 32'h0,   exp_err: 1};
    vecs[6] = '{dim: 2, tr: 1'b1, base: 32'h10, rmode: 2, exp_cnt: 4,  exp_last: 32'h13,  exp_err: 0};
    vecs[7] = '{dim: 3, tr: 1'b1, base: 32'h30, rmode: 2, exp_cnt: 9,  exp_last: 32'h38,  exp_err: 0};

    rst_ni = 1'b0;
    bus.start_i = 1'b0; bus.dim_i = '0; bus.transpose_i = 1'b0;
    bus.in_data_i = '0; bus.in_valid_i = 1'b0; bus.out_ready_i = 1'b0;
    mon_clear();
    repeat (2) @(negedge clk_i);
    check("rst_ready", 32'(bus.in_ready_o), 32'd0);
    check("rst_busy", 32'(bus.busy_o), 32'd0);
    check("rst_valid", 32'(bus.out_valid_o), 32'd0);
    check("rst_addr", 32'(bus.mat_addr_o), 32'd0);
    rst_ni = 1'b1;
    @(negedge clk_i);

    // Directed table
    for (int v = 0; v < 8; v++) begin
      if (vecs[v].exp_err != 0) begin
        run_err(vecs[v].dim);
      end else begin
        for (int k = 0; k < 16; k++) ld_data[k] = vecs[v].base + 32'(k);
        run_cmd(vecs[v].dim, vecs[v].tr, 100, vecs[v].rmode);
        check("tbl_count", 32'(out_data_q.size()), 32'(vecs[v].exp_cnt));
        if (out_data_q.size() > 0) check("tbl_last", out_data_q[$], vecs[v].exp_last);
      end
      check("tbl_err", 32'(err_cnt), 32'(vecs[v].exp_err));
    end

    // Reset in the middle of a load, then a fresh N=2 command
    mon_clear();
    @(negedge clk_i);
    bus.start_i = 1'b1; bus.dim_i = 3'd4; bus.transpose_i = 1'b0;
    @(negedge clk_i);
    bus.start_i = 1'b0;
    for (int k = 0; k < 6; k++) begin
      bus.in_valid_i = 1'b1; bus.in_data_i = 32'hDEAD_0000 + 32'(k);
      @(negedge clk_i);
    end
    check("pre_rst_writes", 32'(wr_addr_q.size()), 32'd6);
    rst_ni = 1'b0;
    #1;
    check("mid_rst_ready", 32'(bus.in_ready_o), 32'd0);
    check("mid_rst_valid", 32'(bus.out_valid_o), 32'd0);
    check("mid_rst_last", 32'(bus.out_last_o), 32'd0);
    check("mid_rst_busy", 32'(bus.busy_o), 32'd0);
    check("mid_rst_done", 32'(bus.done_o), 32'd0);
    check("mid_rst_err", 32'(bus.err_o), 32'd0);
    check("mid_rst_we", 32'(bus.mat_we_o), 32'd0);
    check("mid_rst_addr", 32'(bus.mat_addr_o), 32'd0);
    bus.in_valid_i = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    for (int k = 0; k < 16; k++) ld_data[k] = 32'hC0 + 32'(k);
    run_cmd(2, 1'b0, 100, 0);

    // Randomized commands with random valid gaps and backpressure
    for (int r = 0; r < 12; r++) begin
      int n;
      bit tr;
      n  = int'($urandom_range(MAX_DIM, 1));
      tr = 1'($urandom_range(1));
      for (int k = 0; k < 16; k++) ld_data[k] = $urandom;
      run_cmd(n, tr, 70, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

endmodule
`default_nettype wire
